limber_gnrl_pipechain: RTL and testbench

Parametrised elastic pipeline chain with valid/ready handshake on both sides. It is the handshaked, flushable successor to the plain DFF chain. Each of DP stages holds one DW-bit beat plus a valid bit. Bubbles collapse under backpressure, and occupancy is reported. It is used for timing-cut and latency-matching paths between Limber sub-units where the downstream can stall.

---
 rtl/limber_gnrl_pipechain.sv | 96 +++++++++
 tb/tb_limber_gnrl_pipechain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/limber_gnrl_pipechain.sv
// Elastic valid/ready pipeline chain of DP stages with bubble collapse, synchronous flush
// and registered occupancy count. DP=0 degenerates to a combinational pass-through.
module limber_gnrl_pipechain #(
    parameter int unsigned    DW      = 8,
    parameter int unsigned    DP      = 4,
    parameter logic [DW-1:0]  RST_VAL = '0,
    localparam int unsigned   CW      = (DP == 0) ? 1 : $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_asyn,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] cnt
);

    if (DP == 0) begin : g_pass
        logic w_unused;

        assign o_vld    = i_vld & ~flush;
        assign o_dat    = i_dat;
        assign i_rdy    = o_rdy & ~flush;
        assign cnt      = '0;
        assign w_unused = clk ^ rst_asyn;
    end else begin : g_pipe
        logic [DP-1:0]         r_vld;
        logic [DP-1:0][DW-1:0] r_dat;
        logic [CW-1:0]         r_cnt;
        logic [DP-1:0]         w_rdy;
        logic [DP-1:0]         w_src_vld;
        logic [DP-1:0][DW-1:0] w_src_dat;
        logic [DP-1:0]         w_vld_d;
        logic [DP-1:0][DW-1:0] w_dat_d;
        logic [CW-1:0]         w_cnt_d;
        logic                  w_full;

        // Stage i is ready unless it and every stage downstream of it are full and stalled.
        always_comb begin
            w_rdy  = '0;
            w_full = 1'b1;
            for (int i = DP - 1; i >= 0; i--) begin
                w_full   = w_full & r_vld[i];
                w_rdy[i] = o_rdy | ~w_full;
            end
        end

        always_comb begin
            w_src_vld[0] = i_vld;
            w_src_dat[0] = i_dat;
            for (int i = 1; i < DP; i++) begin
                w_src_vld[i] = r_vld[i-1];
                w_src_dat[i] = r_dat[i-1];
            end
        end

        always_comb begin
            w_vld_d = r_vld;
            w_dat_d = r_dat;
            w_cnt_d = '0;
            if (flush) begin
                w_vld_d = '0;
                w_dat_d = {DP{RST_VAL}};
            end else begin
                for (int i = 0; i < DP; i++) begin
                    if (w_rdy[i]) begin
                        w_vld_d[i] = w_src_vld[i];
                        if (w_src_vld[i]) w_dat_d[i] = w_src_dat[i];
                    end
                end
            end
            for (int i = 0; i < DP; i++) w_cnt_d = w_cnt_d + CW'(w_vld_d[i]);
        end

        always_ff @(posedge clk or posedge rst_asyn) begin
            if (rst_asyn) begin
                r_vld <= '0;
                r_dat <= {DP{RST_VAL}};
                r_cnt <= '0;
            end else begin
                r_vld <= w_vld_d;
                r_dat <= w_dat_d;
                r_cnt <= w_cnt_d;
            end
        end

        assign i_rdy = w_rdy[0] & ~flush;
        assign o_vld = r_vld[DP-1];
        assign o_dat = r_dat[DP-1];
        assign cnt   = r_cnt;
    end

endmodule

// File: tb/tb_limber_gnrl_pipechain.sv
// Directed bench for limber_gnrl_pipechain: a DP=4 chain driven from a vector table plus
// hand-written flush/reset sequences, and a DP=0 pass-through instance.
module tb_limber_gnrl_pipechain;

    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_asyn;
    logic       flush;
    logic       i_vld;
    logic       i_rdy;
    logic [7:0] i_dat;
    logic       o_vld;
    logic       o_rdy;
    logic [7:0] o_dat;
    logic [2:0] cnt;

    logic       z_flush;
    logic       z_ivld;
    logic       z_irdy;
    logic [7:0] z_idat;
    logic       z_ovld;
    logic       z_ordy;
    logic [7:0] z_odat;
    logic [0:0] z_cnt;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    limber_gnrl_pipechain #(.DW(8), .DP(4), .RST_VAL(RV)) u_dut (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .flush    (flush),
        .i_vld    (i_vld),
        .i_rdy    (i_rdy),
        .i_dat    (i_dat),
        .o_vld    (o_vld),
        .o_rdy    (o_rdy),
        .o_dat    (o_dat),
        .cnt      (cnt)
    );

    limber_gnrl_pipechain #(.DW(8), .DP(0), .RST_VAL(RV)) u_dut0 (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .flush    (z_flush),
        .i_vld    (z_ivld),
        .i_rdy    (z_irdy),
        .i_dat    (z_idat),
        .o_vld    (z_ovld),
        .o_rdy    (z_ordy),
        .o_dat    (z_odat),
        .cnt      (z_cnt)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ovld;
        logic [7:0] e_odat;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic e_irdy, input logic e_ovld, input logic [7:0] e_odat,
                       input logic [2:0] e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_odat = e_odat; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        i_vld = iv;
        i_dat = id;
        o_rdy = ordy;
        flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_asyn = 1'b1;
        flush = 1'b0; i_vld = 1'b0; i_dat = 8'h00; o_rdy = 1'b0;
        z_flush = 1'b0; z_ivld = 1'b0; z_idat = 8'h00; z_ordy = 1'b0;

        // Streaming with o_rdy held high
        add(1, 8'h10, 1, 1, 0, 8'h00, 0);
        add(1, 8'h11, 1, 1, 0, 8'h00, 1);
        add(1, 8'h12, 1, 1, 0, 8'h00, 2);
        add(1, 8'h13, 1, 1, 0, 8'h00, 3);
        add(1, 8'h14, 1, 1, 1, 8'h10, 4);
        add(1, 8'h15, 1, 1, 1, 8'h11, 4);
        add(1, 8'h16, 1, 1, 1, 8'h12, 4);
        add(1, 8'h17, 1, 1, 1, 8'h13, 4);
        add(0, 8'h00, 1, 1, 1, 8'h14, 4);
        add(0, 8'h00, 1, 1, 1, 8'h15, 3);
        add(0, 8'h00, 1, 1, 1, 8'h16, 2);
        add(0, 8'h00, 1, 1, 1, 8'h17, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);
        // Backpressure: four accepted, then release
        add(1, 8'hA1, 0, 1, 0, 8'h00, 0);
        add(1, 8'hA2, 0, 1, 0, 8'h00, 1);
        add(1, 8'hA3, 0, 1, 0, 8'h00, 2);
        add(1, 8'hA4, 0, 1, 0, 8'h00, 3);
        add(1, 8'hA5, 0, 0, 1, 8'hA1, 4);
        add(1, 8'hA5, 0, 0, 1, 8'hA1, 4);
        add(1, 8'hA5, 1, 1, 1, 8'hA1, 4);
        add(1, 8'hA6, 1, 1, 1, 8'hA2, 4);
        add(0, 8'h00, 1, 1, 1, 8'hA3, 4);
        add(0, 8'h00, 1, 1, 1, 8'hA4, 3);
        add(0, 8'h00, 1, 1, 1, 8'hA5, 2);
        add(0, 8'h00, 1, 1, 1, 8'hA6, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);
        // Bubble collapse: a beat every other cycle under backpressure
        add(1, 8'hB1, 0, 1, 0, 8'h00, 0);
        add(0, 8'h00, 0, 1, 0, 8'h00, 1);
        add(1, 8'hB2, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 1, 0, 8'h00, 2);
        add(1, 8'hB3, 0, 1, 1, 8'hB1, 2);
        add(0, 8'h00, 0, 1, 1, 8'hB1, 3);
        add(1, 8'hB4, 0, 1, 1, 8'hB1, 3);
        add(1, 8'hB5, 0, 0, 1, 8'hB1, 4);
        add(0, 8'h00, 1, 1, 1, 8'hB1, 4);
        add(0, 8'h00, 1, 1, 1, 8'hB2, 3);
        add(0, 8'h00, 1, 1, 1, 8'hB3, 2);
        add(0, 8'h00, 1, 1, 1, 8'hB4, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);

        // Reset state
        #11;
        chk("rst o_vld", o_vld, 0);
        chk("rst cnt", cnt, 0);
        chk("rst o_dat", o_dat, RV);
        chk("rst i_rdy", i_rdy, 1);
        #1 rst_asyn = 1'b0;
        tick();

        foreach (tbl[k]) begin
            drive(tbl[k].iv, tbl[k].id, tbl[k].ordy, 1'b0);
            chk($sformatf("row%0d i_rdy", k), i_rdy, tbl[k].e_irdy);
            chk($sformatf("row%0d o_vld", k), o_vld, tbl[k].e_ovld);
            chk($sformatf("row%0d cnt", k), cnt, tbl[k].e_cnt);
            if (tbl[k].e_ovld) chk($sformatf("row%0d o_dat", k), o_dat, tbl[k].e_odat);
            tick();
        end

        // Flush with three beats held and an offered input
        drive(1, 8'hC1, 0, 0); tick();
        drive(1, 8'hC2, 0, 0); tick();
        drive(1, 8'hC3, 0, 0); tick();
        drive(1, 8'hC4, 0, 1);
        chk("flush i_rdy", i_rdy, 0);
        chk("flush cnt before", cnt, 3);
        tick();
        drive(0, 8'h00, 0, 0);
        chk("flush cnt after", cnt, 0);
        chk("flush o_vld after", o_vld, 0);
        chk("flush o_dat after", o_dat, RV);
        tick();
        drive(1, 8'h55, 1, 0);
        chk("post-flush i_rdy", i_rdy, 1);
        tick();
        for (int j = 1; j <= 6; j++) begin
            drive(0, 8'h00, 1, 0);
            chk($sformatf("post-flush o_vld c%0d", j), o_vld, (j == 4) ? 1 : 0);
            if (j == 4) chk("post-flush o_dat", o_dat, 8'h55);
            tick();
        end

        // Asynchronous reset with beats in flight
        drive(1, 8'hD1, 0, 0); tick();
        drive(1, 8'hD2, 0, 0); tick();
        drive(1, 8'hD3, 0, 0); tick();
        drive(1, 8'hD4, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        chk("pre-reset cnt", cnt, 4);
        chk("pre-reset o_dat", o_dat, 8'hD1);
        rst_asyn = 1'b1;
        #1;
        chk("mid-reset o_vld", o_vld, 0);
        chk("mid-reset cnt", cnt, 0);
        chk("mid-reset o_dat", o_dat, RV);
        #2 rst_asyn = 1'b0;
        #1;
        chk("post-reset i_rdy", i_rdy, 1);
        tick();
        for (int j = 0; j < 5; j++) begin
            drive(0, 8'h00, 1, 0);
            chk($sformatf("post-reset o_vld c%0d", j), o_vld, 0);
            tick();
        end

        // DP=0 pass-through
        for (int j = 0; j < 12; j++) begin
            z_ivld  = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            z_ordy  = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            z_flush = (j == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            z_idat  = 8'($urandom);
            #1;
            chk($sformatf("dp0 o_vld %0d", j), z_ovld, z_ivld & ~z_flush);
            chk($sformatf("dp0 i_rdy %0d", j), z_irdy, z_ordy & ~z_flush);
            chk($sformatf("dp0 o_dat %0d", j), z_odat, z_idat);
            chk($sformatf("dp0 cnt %0d", j), z_cnt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
